// File: rtl/mc_controller.sv
// mc_controller -- main sequencing FSM of the multicycle RV32I core.
//
// Steps the shared ALU, the unified instruction/data memory port, the PC and
// the register file through fetch / decode / execute / memory / writeback,
// and counts retired instructions.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   op[6:0]             opcode from the instruction register
//   mem_ready           memory handshake completes this cycle
//   mem_req, MemWrite   memory request and store strobe
//   AdrSrc              memory address select (0 PC, 1 Result)
//   IRWrite, PCUpdate   load IR/OldPC, unconditional PC write
//   Branch, RegWrite    conditional PC write, register file write
//   ALUSrcA/B, ALUOp    ALU operand selects and operation class
//   ResultSrc           result bus select
//   illegal             illegal opcode indication
//   instret[CNT_W-1:0]  retired instruction count (wraps)
module mc_controller #(
  parameter int CNT_W           = 32,
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [6:0]       op,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             MemWrite,
  output logic             AdrSrc,
  output logic             IRWrite,
  output logic             PCUpdate,
  output logic             Branch,
  output logic             RegWrite,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       ResultSrc,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LINK,
    S_LUI, S_AUIPC, S_TRAP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             retire;

  // Raw strobes before reset gating.
  logic mem_req_s, mem_write_s, ir_write_s, pc_update_s, branch_s, reg_write_s;

  // ---- state and counter registers ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  // ---- next state ----
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        unique case (op)
          7'b0000011, 7'b0100011: state_d = S_MEMADR;
          7'b0110011:             state_d = S_EXECR;
          7'b0010011:             state_d = S_EXECI;
          7'b1100011:             state_d = S_BRANCH;
          7'b1101111:             state_d = S_JAL;
          7'b1100111:             state_d = S_JALR;
          7'b0110111:             state_d = S_LUI;
          7'b0010111:             state_d = S_AUIPC;
          default:                state_d = S_TRAP;
        endcase
      end
      // op[5] separates stores (0100011) from loads (0000011).
      S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_JALR:     state_d = S_LINK;
      S_LINK:     state_d = S_ALUWB;
      S_LUI:      state_d = S_ALUWB;
      S_AUIPC:    state_d = S_ALUWB;
      S_TRAP:     state_d = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // ---- retire counting: every path that completes an instruction into FETCH ----
  always_comb begin
    retire = (state_q == S_ALUWB) || (state_q == S_MEMWB) ||
             (state_q == S_BRANCH) || ((state_q == S_MEMWRITE) && mem_ready);
    instret_d = instret_q;
    if (retire) instret_d = instret_q + CNT_W'(1);
  end

  // ---- outputs ----
  always_comb begin
    mem_req_s   = 1'b0;
    mem_write_s = 1'b0;
    ir_write_s  = 1'b0;
    pc_update_s = 1'b0;
    branch_s    = 1'b0;
    reg_write_s = 1'b0;
    AdrSrc      = 1'b0;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    ResultSrc   = 2'b00;
    illegal     = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_req_s   = 1'b1;
        ALUSrcB     = 2'b10;
        ResultSrc   = 2'b10;
        ir_write_s  = mem_ready;
        pc_update_s = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: begin
        mem_req_s = 1'b1;
        AdrSrc    = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc   = 2'b01;
        reg_write_s = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req_s   = 1'b1;
        AdrSrc      = 1'b1;
        mem_write_s = mem_ready;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      S_ALUWB:  reg_write_s = 1'b1;
      S_BRANCH: begin
        ALUSrcA  = 2'b10;
        ALUOp    = 2'b01;
        branch_s = 1'b1;
      end
      S_JAL: begin
        ALUSrcA     = 2'b01;
        ALUSrcB     = 2'b10;
        pc_update_s = 1'b1;
      end
      // PC takes rs1+imm straight off the ALU while OldPC+4 is formed next.
      S_JALR: begin
        ALUSrcA     = 2'b10;
        ALUSrcB     = 2'b01;
        ResultSrc   = 2'b10;
        pc_update_s = 1'b1;
      end
      S_LINK: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
      end
      S_LUI: begin
        ALUSrcA = 2'b11;
        ALUSrcB = 2'b01;
      end
      S_AUIPC: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_TRAP:  illegal = 1'b1;
      default: ;
    endcase
  end

  // Strobes are gated by reset_n so they drop the instant reset asserts,
  // independent of the clock.
  assign mem_req  = mem_req_s   & reset_n;
  assign MemWrite = mem_write_s & reset_n;
  assign IRWrite  = ir_write_s  & reset_n;
  assign PCUpdate = pc_update_s & reset_n;
  assign Branch   = branch_s    & reset_n;
  assign RegWrite = reg_write_s & reset_n;
  assign instret  = instret_q;

endmodule

// File: tb/tb_mc_controller.sv
module tb_mc_controller;

  localparam int CNT_W = 32;

  logic       clk;
  logic       reset_n;
  logic [6:0] op;
  logic       mem_ready;

  // Main instance: trap halts.
  logic             mem_req, MemWrite, AdrSrc, IRWrite, PCUpdate, Branch, RegWrite, illegal;
  logic [1:0]       ALUSrcA, ALUSrcB, ALUOp, ResultSrc;
  logic [CNT_W-1:0] instret;
  // Alternate instance: trap pulses for one cycle.
  logic             a_mem_req, a_MemWrite, a_AdrSrc, a_IRWrite, a_PCUpdate, a_Branch, a_RegWrite, a_illegal;
  logic [1:0]       a_ALUSrcA, a_ALUSrcB, a_ALUOp, a_ResultSrc;
  logic [CNT_W-1:0] a_instret;

  mc_controller #(.CNT_W(CNT_W), .TRAP_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .op(op), .mem_ready(mem_ready),
    .mem_req(mem_req), .MemWrite(MemWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
    .PCUpdate(PCUpdate), .Branch(Branch), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ResultSrc(ResultSrc),
    .illegal(illegal), .instret(instret)
  );

  mc_controller #(.CNT_W(CNT_W), .TRAP_ON_ILLEGAL(1'b0)) dut_alt (
    .clk(clk), .reset_n(reset_n), .op(op), .mem_ready(mem_ready),
    .mem_req(a_mem_req), .MemWrite(a_MemWrite), .AdrSrc(a_AdrSrc), .IRWrite(a_IRWrite),
    .PCUpdate(a_PCUpdate), .Branch(a_Branch), .RegWrite(a_RegWrite),
    .ALUSrcA(a_ALUSrcA), .ALUSrcB(a_ALUSrcB), .ALUOp(a_ALUOp), .ResultSrc(a_ResultSrc),
    .illegal(a_illegal), .instret(a_instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output vectors:
  // {mem_req,MemWrite,AdrSrc,IRWrite,PCUpdate,Branch,RegWrite}_ALUSrcA_ALUSrcB_ALUOp_ResultSrc_illegal
  localparam logic [15:0] V_RST  = 16'b0000000_00_10_00_10_0;
  localparam logic [15:0] V_FWT  = 16'b1000000_00_10_00_10_0;
  localparam logic [15:0] V_FGO  = 16'b1001100_00_10_00_10_0;
  localparam logic [15:0] V_DEC  = 16'b0000000_01_01_00_00_0;
  localparam logic [15:0] V_MADR = 16'b0000000_10_01_00_00_0;
  localparam logic [15:0] V_MRD  = 16'b1010000_00_00_00_00_0;
  localparam logic [15:0] V_MWB  = 16'b0000001_00_00_00_01_0;
  localparam logic [15:0] V_MWR  = 16'b1110000_00_00_00_00_0;
  localparam logic [15:0] V_MWRW = 16'b1010000_00_00_00_00_0;
  localparam logic [15:0] V_EXR  = 16'b0000000_10_00_10_00_0;
  localparam logic [15:0] V_EXI  = 16'b0000000_10_01_10_00_0;
  localparam logic [15:0] V_AWB  = 16'b0000001_00_00_00_00_0;
  localparam logic [15:0] V_BR   = 16'b0000010_10_00_01_00_0;
  localparam logic [15:0] V_JAL  = 16'b0000100_01_10_00_00_0;
  localparam logic [15:0] V_JALR = 16'b0000100_10_01_00_10_0;
  localparam logic [15:0] V_LINK = 16'b0000000_01_10_00_00_0;
  localparam logic [15:0] V_LUI  = 16'b0000000_11_01_00_00_0;
  localparam logic [15:0] V_AUI  = 16'b0000000_01_01_00_00_0;
  localparam logic [15:0] V_TRAP = 16'b0000000_00_00_00_00_1;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LW = 7'b0000011,
                         OP_SW = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUI = 7'b0010111;

  typedef struct {
    logic [15:0]      vec;
    logic [CNT_W-1:0] cnt;
    string            name;
  } exp_t;

  exp_t             sb[$];
  int               checks = 0;
  int               errors = 0;
  logic [CNT_W-1:0] exp_instret = '0;
  bit               use_alt = 1'b0;

  function automatic logic [15:0] obs_vec();
    if (use_alt)
      return {a_mem_req, a_MemWrite, a_AdrSrc, a_IRWrite, a_PCUpdate, a_Branch, a_RegWrite,
              a_ALUSrcA, a_ALUSrcB, a_ALUOp, a_ResultSrc, a_illegal};
    return {mem_req, MemWrite, AdrSrc, IRWrite, PCUpdate, Branch, RegWrite,
            ALUSrcA, ALUSrcB, ALUOp, ResultSrc, illegal};
  endfunction

  function automatic logic [CNT_W-1:0] obs_cnt();
    return use_alt ? a_instret : instret;
  endfunction

  // One clock: drive inputs, queue the expectation, compare at the falling
  // edge, then step past the rising edge. Called at posedge+1.
  task automatic cycle(input logic [6:0] o, input logic rdy, input logic [15:0] ev,
                       input bit retire, input string nm);
    exp_t e;
    exp_t g;
    logic [15:0]      v;
    logic [CNT_W-1:0] c;
    op        = o;
    mem_ready = rdy;
    e.vec  = ev;
    e.cnt  = exp_instret;
    e.name = nm;
    sb.push_back(e);
    @(negedge clk);
    g = sb.pop_front();
    v = obs_vec();
    c = obs_cnt();
    checks++;
    if (v !== g.vec) begin
      errors++;
      $display("FAIL %s outputs act=%b req=%b t=%0t", g.name, v, g.vec, $time);
    end
    checks++;
    if (c !== g.cnt) begin
      errors++;
      $display("FAIL %s instret act=%0d req=%0d t=%0t", g.name, c, g.cnt, $time);
    end
    @(posedge clk);
    #1;
    if (retire) exp_instret = exp_instret + 1'b1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n     = 1'b1;
    exp_instret = '0;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    mem_ready = 1'b1;
    op        = OP_R;
    @(negedge clk);
    checks++;
    if (obs_vec() !== V_RST) begin
      errors++;
      $display("FAIL reset_outputs act=%b req=%b", obs_vec(), V_RST);
    end
    checks++;
    if (instret !== '0 || a_instret !== '0) begin
      errors++;
      $display("FAIL reset_instret act=%0d/%0d req=0", instret, a_instret);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_rtype();
    cycle(OP_R, 1'b1, V_FGO, 1'b0, "r_fetch");
    cycle(OP_R, 1'b1, V_DEC, 1'b0, "r_decode");
    cycle(OP_R, 1'b1, V_EXR, 1'b0, "r_execr");
    cycle(OP_R, 1'b1, V_AWB, 1'b1, "r_aluwb");
    cycle(OP_R, 1'b0, V_FWT, 1'b0, "r_next_fetch_wait");
  endtask

  // Opcode is scrambled during MEMREAD to show it is ignored there.
  task automatic test_load_wait();
    cycle(OP_LW, 1'b1, V_FGO,  1'b0, "lw_fetch");
    cycle(OP_LW, 1'b1, V_DEC,  1'b0, "lw_decode");
    cycle(OP_LW, 1'b1, V_MADR, 1'b0, "lw_memadr");
    cycle(7'h7f, 1'b0, V_MRD,  1'b0, "lw_memread_w1");
    cycle(OP_SW, 1'b0, V_MRD,  1'b0, "lw_memread_w2");
    cycle(7'h00, 1'b1, V_MRD,  1'b0, "lw_memread_go");
    cycle(7'h00, 1'b1, V_MWB,  1'b1, "lw_memwb");
  endtask

  task automatic test_store();
    cycle(OP_SW, 1'b0, V_FWT,  1'b0, "sw_fetch_wait");
    cycle(OP_SW, 1'b1, V_FGO,  1'b0, "sw_fetch");
    cycle(OP_SW, 1'b1, V_DEC,  1'b0, "sw_decode");
    cycle(OP_SW, 1'b1, V_MADR, 1'b0, "sw_memadr");
    cycle(OP_SW, 1'b1, V_MWR,  1'b1, "sw_memwrite");
  endtask

  task automatic test_jal_jalr();
    cycle(OP_JAL,  1'b1, V_FGO,  1'b0, "jal_fetch");
    cycle(OP_JAL,  1'b1, V_DEC,  1'b0, "jal_decode");
    cycle(OP_JAL,  1'b1, V_JAL,  1'b0, "jal_jal");
    cycle(OP_JAL,  1'b1, V_AWB,  1'b1, "jal_aluwb");
    cycle(OP_JALR, 1'b1, V_FGO,  1'b0, "jalr_fetch");
    cycle(OP_JALR, 1'b1, V_DEC,  1'b0, "jalr_decode");
    cycle(OP_JALR, 1'b1, V_JALR, 1'b0, "jalr_jalr");
    cycle(OP_JALR, 1'b1, V_LINK, 1'b0, "jalr_link");
    cycle(OP_JALR, 1'b1, V_AWB,  1'b1, "jalr_aluwb");
  endtask

  task automatic test_back_to_back();
    logic [6:0]  ops [5] = '{OP_I, OP_LUI, OP_AUI, OP_BR, OP_R};
    logic [15:0] evs [5] = '{V_EXI, V_LUI, V_AUI, V_BR, V_EXR};
    bit          wbs [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      cycle(ops[i], 1'b1, V_FGO, 1'b0, $sformatf("b2b%0d_fetch", i));
      cycle(ops[i], 1'b1, V_DEC, 1'b0, $sformatf("b2b%0d_decode", i));
      if (wbs[i]) begin
        cycle(ops[i], 1'b1, evs[i], 1'b0, $sformatf("b2b%0d_exec", i));
        cycle(ops[i], 1'b1, V_AWB,  1'b1, $sformatf("b2b%0d_aluwb", i));
      end else begin
        cycle(ops[i], 1'b1, evs[i], 1'b1, $sformatf("b2b%0d_branch", i));
      end
    end
  endtask

  task automatic test_trap_halt();
    cycle(7'h00, 1'b1, V_FGO, 1'b0, "trap_fetch");
    cycle(7'h00, 1'b1, V_DEC, 1'b0, "trap_decode");
    for (int i = 0; i < 22; i++)
      cycle((i % 2 == 0) ? OP_R : 7'h00, 1'b1, V_TRAP, 1'b0, "trap_hold");
    reset_n = 1'b0;
    #2;
    checks++;
    if (obs_vec() !== V_RST) begin
      errors++;
      $display("FAIL trap_reset_outputs act=%b req=%b", obs_vec(), V_RST);
    end
    @(posedge clk);
    #1;
    reset_n     = 1'b1;
    exp_instret = '0;
    cycle(OP_R, 1'b1, V_FGO, 1'b0, "trap_after_reset_fetch");
    cycle(OP_R, 1'b1, V_DEC, 1'b0, "trap_after_reset_decode");
  endtask

  task automatic test_trap_pulse();
    do_reset();
    use_alt = 1'b1;
    cycle(7'h00, 1'b1, V_FGO,  1'b0, "pulse_fetch");
    cycle(7'h00, 1'b1, V_DEC,  1'b0, "pulse_decode");
    cycle(7'h00, 1'b1, V_TRAP, 1'b0, "pulse_trap");
    cycle(OP_R,  1'b1, V_FGO,  1'b0, "pulse_refetch");
    cycle(OP_R,  1'b1, V_DEC,  1'b0, "pulse_decode2");
    cycle(OP_R,  1'b1, V_EXR,  1'b0, "pulse_execr");
    cycle(OP_R,  1'b1, V_AWB,  1'b1, "pulse_aluwb");
    cycle(OP_R,  1'b0, V_FWT,  1'b0, "pulse_fetch_wait");
    use_alt = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    cycle(OP_R,  1'b1, V_FGO,  1'b0, "ar_r_fetch");
    cycle(OP_R,  1'b1, V_DEC,  1'b0, "ar_r_decode");
    cycle(OP_R,  1'b1, V_EXR,  1'b0, "ar_r_execr");
    cycle(OP_R,  1'b1, V_AWB,  1'b1, "ar_r_aluwb");
    cycle(OP_SW, 1'b1, V_FGO,  1'b0, "ar_fetch");
    cycle(OP_SW, 1'b1, V_DEC,  1'b0, "ar_decode");
    cycle(OP_SW, 1'b1, V_MADR, 1'b0, "ar_memadr");
    cycle(OP_SW, 1'b0, V_MWRW, 1'b0, "ar_memwrite_wait");
    // Between clock edges: ready rises, then reset asserts asynchronously.
    mem_ready = 1'b1;
    #1;
    checks++;
    if ({mem_req, MemWrite} !== 2'b11) begin
      errors++;
      $display("FAIL ar_memwrite_ready act=%b req=11", {mem_req, MemWrite});
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (obs_vec() !== V_RST) begin
      errors++;
      $display("FAIL ar_strobes_drop act=%b req=%b", obs_vec(), V_RST);
    end
    checks++;
    if (instret !== '0) begin
      errors++;
      $display("FAIL ar_instret act=%0d req=0", instret);
    end
    @(posedge clk);
    #1;
    reset_n     = 1'b1;
    exp_instret = '0;
    cycle(OP_R, 1'b0, V_FWT, 1'b0, "ar_after_fetch_wait");
    cycle(OP_R, 1'b1, V_FGO, 1'b0, "ar_after_fetch");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rtype();
    test_load_wait();
    test_store();
    test_jal_jalr();
    test_back_to_back();
    test_trap_halt();
    test_trap_pulse();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
